mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter for one shared memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate simultaneous grants; default is fixed ls priority.
module mem_port_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LP_WS_LAST = 3'(WAIT_STATES);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic        r_sel_ls;
    logic        w_sel_ls_next;

    logic        r_if_gnt;
    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_ls_gnt;
    logic        r_ls_rvalid;
    logic [31:0] r_ls_rdata;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_busy;

    logic        w_if_gnt_next;
    logic        w_if_rvalid_next;
    logic [31:0] w_if_rdata_next;
    logic        w_ls_gnt_next;
    logic        w_ls_rvalid_next;
    logic [31:0] w_ls_rdata_next;
    logic        w_mem_en_next;
    logic        w_mem_we_next;
    logic [31:0] w_mem_addr_next;
    logic [31:0] w_mem_wdata_next;
    logic        w_busy_next;

    logic        w_start;
    logic        w_last;
    logic        w_pick_ls;

    assign w_start = (r_state == ST_IDLE) && (if_req || ls_req);
    assign w_last  = (r_cnt == LP_WS_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    // r_rr_ls high means ls is favoured on the next simultaneous request.
    logic r_rr_ls;

    assign w_pick_ls = ls_req && (!if_req || r_rr_ls);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ls <= 1'b1;
        end else if (w_start) begin
            r_rr_ls <= !w_pick_ls;
        end
    end
`else
    assign w_pick_ls = ls_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_sel_ls <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_sel_ls <= w_sel_ls_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_sel_ls_next    = r_sel_ls;
        w_if_gnt_next    = 1'b0;
        w_if_rvalid_next = 1'b0;
        w_if_rdata_next  = r_if_rdata;
        w_ls_gnt_next    = 1'b0;
        w_ls_rvalid_next = 1'b0;
        w_ls_rdata_next  = r_ls_rdata;
        w_mem_en_next    = 1'b0;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next  = ST_ACCESS;
                    w_cnt_next    = 3'd0;
                    w_sel_ls_next = w_pick_ls;
                    w_mem_en_next = 1'b1;
                    if (w_pick_ls) begin
                        w_ls_gnt_next    = 1'b1;
                        w_mem_we_next    = ls_we;
                        w_mem_addr_next  = ls_addr;
                        w_mem_wdata_next = ls_wdata;
                    end else begin
                        w_if_gnt_next    = 1'b1;
                        w_mem_we_next    = 1'b0;
                        w_mem_addr_next  = if_addr;
                        w_mem_wdata_next = 32'd0;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_last) begin
                    // mem_rdata is captured on the final access cycle.
                    w_state_next  = ST_DONE;
                    w_cnt_next    = 3'd0;
                    w_mem_we_next = 1'b0;
                    if (r_sel_ls) begin
                        w_ls_rvalid_next = 1'b1;
                        w_ls_rdata_next  = r_mem_we ? 32'd0 : mem_rdata;
                    end else begin
                        w_if_rvalid_next = 1'b1;
                        w_if_rdata_next  = mem_rdata;
                    end
                end else begin
                    w_cnt_next    = r_cnt + 3'd1;
                    w_mem_en_next = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_ls_gnt    <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_ls_rdata  <= 32'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_if_gnt    <= w_if_gnt_next;
            r_if_rvalid <= w_if_rvalid_next;
            r_if_rdata  <= w_if_rdata_next;
            r_ls_gnt    <= w_ls_gnt_next;
            r_ls_rvalid <= w_ls_rvalid_next;
            r_ls_rdata  <= w_ls_rdata_next;
            r_mem_en    <= w_mem_en_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_busy      <= w_busy_next;
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_gnt    = r_ls_gnt;
    assign ls_rvalid = r_ls_rvalid;
    assign ls_rdata  = r_ls_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_STATES=1 main instance plus 0 and 7 instances.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = 32'd0, ls_addr = 32'd0, ls_wdata = 32'd0, mem_rdata = 32'd0;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

    logic        x_ls_req = 1'b0;
    logic [31:0] x_ls_addr = 32'd0, x_mem_rdata = 32'd0;
    logic        z0_if_gnt, z0_if_rvalid, z0_ls_gnt, z0_ls_rvalid, z0_mem_en, z0_mem_we, z0_busy;
    logic [31:0] z0_if_rdata, z0_ls_rdata, z0_mem_addr, z0_mem_wdata;
    logic        z7_if_gnt, z7_if_rvalid, z7_ls_gnt, z7_ls_rvalid, z7_mem_en, z7_mem_we, z7_busy;
    logic [31:0] z7_if_rdata, z7_ls_rdata, z7_mem_addr, z7_mem_wdata;

    wire [134:0] all_out = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                            mem_en, mem_we, mem_addr, mem_wdata, busy};

    int tests = 0;
    int failed = 0;

    mem_port_arbiter #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'd0), .if_gnt(z0_if_gnt), .if_rvalid(z0_if_rvalid), .if_rdata(z0_if_rdata),
        .ls_req(x_ls_req), .ls_we(1'b0), .ls_addr(x_ls_addr), .ls_wdata(32'd0),
        .ls_gnt(z0_ls_gnt), .ls_rvalid(z0_ls_rvalid), .ls_rdata(z0_ls_rdata),
        .mem_en(z0_mem_en), .mem_we(z0_mem_we), .mem_addr(z0_mem_addr), .mem_wdata(z0_mem_wdata),
        .mem_rdata(x_mem_rdata), .busy(z0_busy)
    );

    mem_port_arbiter #(.WAIT_STATES(7)) dut_ws7 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'd0), .if_gnt(z7_if_gnt), .if_rvalid(z7_if_rvalid), .if_rdata(z7_if_rdata),
        .ls_req(x_ls_req), .ls_we(1'b0), .ls_addr(x_ls_addr), .ls_wdata(32'd0),
        .ls_gnt(z7_ls_gnt), .ls_rvalid(z7_ls_rvalid), .ls_rdata(z7_ls_rdata),
        .mem_en(z7_mem_en), .mem_we(z7_mem_we), .mem_addr(z7_mem_addr), .mem_wdata(z7_mem_wdata),
        .mem_rdata(x_mem_rdata), .busy(z7_busy)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (all_out !== 135'd0) begin failed++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        tests++; if ({z0_busy, z7_busy, z0_mem_en, z7_mem_en} !== 4'b0000) begin failed++; $display("FAIL reset_ws_insts: got %b want 0000", {z0_busy, z7_busy, z0_mem_en, z7_mem_en}); end
        rst = 1'b0;
        tick;
        tests++; if (all_out !== 135'd0) begin failed++; $display("FAIL idle_after_reset: got %h want 0", all_out); end
        $display("[TB] reset checked");
    endtask

    task automatic test_if_read;
        if_req = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h1234_5037;
        tick;  // T+1
        if_req = 1'b0;
        tests++; if ({if_gnt, ls_gnt, mem_en, mem_we, busy} !== 5'b10101) begin failed++; $display("FAIL if_read_T1 gnt/gnt/en/we/busy: got %b want 10101", {if_gnt, ls_gnt, mem_en, mem_we, busy}); end
        tests++; if (mem_addr !== 32'h0000_0010) begin failed++; $display("FAIL if_read_addr: got %h want 00000010", mem_addr); end
        tick;  // T+2
        tests++; if ({if_gnt, mem_en, if_rvalid} !== 3'b010) begin failed++; $display("FAIL if_read_T2 gnt/en/rvalid: got %b want 010", {if_gnt, mem_en, if_rvalid}); end
        tick;  // T+3
        tests++; if ({if_rvalid, mem_en, busy, ls_rvalid} !== 4'b1010) begin failed++; $display("FAIL if_read_T3 rvalid/en/busy/ls_rvalid: got %b want 1010", {if_rvalid, mem_en, busy, ls_rvalid}); end
        tests++; if (if_rdata !== 32'h1234_5037) begin failed++; $display("FAIL if_read_rdata: got %h want 12345037", if_rdata); end
        mem_rdata = 32'h0;
        tick;  // T+4
        tests++; if ({if_rvalid, busy} !== 2'b00 || if_rdata !== 32'h1234_5037) begin failed++; $display("FAIL if_read_T4 hold: rvalid/busy %b rdata %h want 00 12345037", {if_rvalid, busy}, if_rdata); end
        $display("[TB] if read addr=00000010 data=%h", if_rdata);
    endtask

    task automatic test_ls_write;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0100; ls_wdata = 32'hFFFF_F000; mem_rdata = 32'hDEAD_BEEF;
        tick;  // T+1
        ls_req = 1'b0; ls_we = 1'b0;
        tests++; if ({ls_gnt, if_gnt, mem_en, mem_we} !== 4'b1011) begin failed++; $display("FAIL ls_write_T1 lsgnt/ifgnt/en/we: got %b want 1011", {ls_gnt, if_gnt, mem_en, mem_we}); end
        tests++; if (mem_addr !== 32'h0000_0100 || mem_wdata !== 32'hFFFF_F000) begin failed++; $display("FAIL ls_write_T1 addr/wdata: got %h %h want 00000100 fffff000", mem_addr, mem_wdata); end
        tick;  // T+2
        tests++; if ({ls_gnt, mem_en, mem_we} !== 3'b011 || mem_addr !== 32'h0000_0100 || mem_wdata !== 32'hFFFF_F000) begin failed++; $display("FAIL ls_write_T2 stable: gnt/en/we %b addr %h wdata %h", {ls_gnt, mem_en, mem_we}, mem_addr, mem_wdata); end
        tick;  // T+3
        tests++; if ({ls_rvalid, if_rvalid, if_gnt, mem_en} !== 4'b1000 || ls_rdata !== 32'd0) begin failed++; $display("FAIL ls_write_T3 rvalid/ifrv/ifgnt/en %b rdata %h want 1000 0", {ls_rvalid, if_rvalid, if_gnt, mem_en}, ls_rdata); end
        tick;
        tests++; if ({ls_rvalid, busy} !== 2'b00 || if_rdata !== 32'h1234_5037) begin failed++; $display("FAIL ls_write_T4 rvalid/busy %b if_rdata %h", {ls_rvalid, busy}, if_rdata); end
        $display("[TB] ls write addr=00000100 data=fffff000");
    endtask

    task automatic test_simultaneous;
        logic [2:0] got;
        logic [2:0] want;
        int n;
`ifdef ARB_ROUND_ROBIN_EN
        want = 3'b101;
`else
        want = 3'b111;
`endif
        got = 3'b000;
        rst = 1'b1; tick; rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0300;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200; mem_rdata = 32'h5555_AAAA;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            tick;
            while (!(if_gnt || ls_gnt) && n < 10) begin tick; n++; end
            tests++; if (!(if_gnt || ls_gnt) || (if_gnt && ls_gnt)) begin failed++; $display("FAIL simul_grant%0d: if_gnt %b ls_gnt %b want exactly one", g, if_gnt, ls_gnt); end
            got[2-g] = ls_gnt;
            $display("[TB] simultaneous grant %0d to %s", g, ls_gnt ? "ls" : "if");
        end
        if_req = 1'b0; ls_req = 1'b0;
        tests++; if (got !== want) begin failed++; $display("FAIL simul_order (1=ls): got %b want %b", got, want); end
        for (int k = 0; k < 6; k++) tick;
    endtask

    task automatic test_reset_abort;
        int rv;
        rv = 0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0040; mem_rdata = 32'h7777_0000;
        tick;  // T+1
        ls_req = 1'b0;
        tests++; if (ls_gnt !== 1'b1) begin failed++; $display("FAIL abort_gnt: got %b want 1", ls_gnt); end
        tick;  // T+2
        rst = 1'b1;
        #1;
        tests++; if (all_out !== 135'd0) begin failed++; $display("FAIL abort_outputs_zero: got %h want 0", all_out); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin tick; if (ls_rvalid || busy) rv++; end
        tests++; if (rv != 0) begin failed++; $display("FAIL abort_no_rvalid: got %0d active cycles want 0", rv); end
        if_req = 1'b1; if_addr = 32'h0000_0044; mem_rdata = 32'hA5A5_5A5A;
        tick;
        if_req = 1'b0;
        tests++; if (if_gnt !== 1'b1 || mem_addr !== 32'h0000_0044) begin failed++; $display("FAIL abort_next_gnt: gnt %b addr %h want 1 00000044", if_gnt, mem_addr); end
        tick; tick;
        tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_5A5A) begin failed++; $display("FAIL abort_next_rvalid: rvalid %b rdata %h want 1 a5a55a5a", if_rvalid, if_rdata); end
        tick;
        $display("[TB] reset abort then if read data=%h", if_rdata);
    endtask

    task automatic test_wait_states;
        int rv0, rv7, en0, en7;
        logic [31:0] d0, d7;
        rv0 = 0; rv7 = 0; en0 = 0; en7 = 0; d0 = 32'd0; d7 = 32'd0;
        x_ls_req = 1'b1; x_ls_addr = 32'h0000_0080; x_mem_rdata = 32'h0BAD_F00D;
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 1) begin
                x_ls_req = 1'b0;
                tests++; if ({z0_ls_gnt, z7_ls_gnt} !== 2'b11) begin failed++; $display("FAIL ws_gnt: got %b want 11", {z0_ls_gnt, z7_ls_gnt}); end
            end
            if (z0_mem_en) en0++;
            if (z7_mem_en) en7++;
            if (z0_ls_rvalid && rv0 == 0) begin rv0 = k; d0 = z0_ls_rdata; end
            if (z7_ls_rvalid && rv7 == 0) begin rv7 = k; d7 = z7_ls_rdata; end
        end
        tests++; if (rv0 != 2 || en0 != 1) begin failed++; $display("FAIL ws0 latency/en_width: got %0d/%0d want 2/1", rv0, en0); end
        tests++; if (rv7 != 9 || en7 != 8) begin failed++; $display("FAIL ws7 latency/en_width: got %0d/%0d want 9/8", rv7, en7); end
        tests++; if (d0 !== 32'h0BAD_F00D || d7 !== 32'h0BAD_F00D) begin failed++; $display("FAIL ws_rdata: got %h %h want 0badf00d", d0, d7); end
        $display("[TB] wait-state loads ws0 rvalid@%0d ws7 rvalid@%0d", rv0, rv7);
    endtask

    task automatic test_busy_ignore;
        int ifg;
        ifg = 0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0020; mem_rdata = 32'h0000_1111;
        tick;  // T+1
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0099;
        tick;  // T+2
        if_req = 1'b0;
        if (if_gnt) ifg++;
        tick;  // T+3
        if (if_gnt) ifg++;
        tests++; if ({ls_rvalid, busy} !== 2'b11 || ls_rdata !== 32'h0000_1111) begin failed++; $display("FAIL busy_T3 rvalid/busy %b rdata %h want 11 00001111", {ls_rvalid, busy}, ls_rdata); end
        tick;  // T+4
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL busy_falls: got %b want 0", busy); end
        for (int k = 0; k < 4; k++) begin tick; if (if_gnt || busy) ifg++; end
        tests++; if (ifg != 0) begin failed++; $display("FAIL busy_ignore_if: got %0d grant/busy cycles want 0", ifg); end
        $display("[TB] ls load with ignored if pulse data=%h", ls_rdata);
    endtask

    initial begin
        test_reset;
        test_if_read;
        test_ls_write;
        test_simultaneous;
        test_reset_abort;
        test_wait_states;
        test_busy_ignore;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
